// File: rtl/div_unit_pkg.sv
// Shared constants and FSM encoding for the iterative integer divider.
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;

  localparam logic RstEnable         = 1'b1;
  localparam logic Stop              = 1'b1;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivAnnul          = 1'b1;
  localparam logic DivNotAnnul       = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, set quotient bit.
module div_unit_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted_s;
  logic [DATA_W:0] diff_s;

  // Borrow out of the extra top bit means the trial subtract went negative.
  always_comb begin
    shifted_s = {rem_i, quo_i[DATA_W-1]};
    diff_s    = shifted_s - {1'b0, dvs_i};
    if (diff_s[DATA_W] == 1'b0) begin
      rem_o = diff_s[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o = shifted_s[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: magnitude restoring division, sign fix-up at the end,
// result held until EX drops start_i.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave div_bus
);

  localparam logic [5:0] LastCnt = 6'(DATA_W);

  div_state_e           state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [DATA_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]    quo_q, quo_d;
  logic [DATA_W-1:0]    dvs_q, dvs_d;
  logic                 sgn_q, sgn_d;
  logic                 neg1_q, neg1_d;
  logic                 neg2_q, neg2_d;
  logic                 ready_q, ready_d;
  logic [2*DATA_W-1:0]  result_q, result_d;
  logic [DATA_W-1:0]    step_rem_s, step_quo_s;

  function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  div_unit_step #(.DATA_W(DATA_W)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem_s),
    .quo_o (step_quo_s)
  );

  // State, counter and datapath registers
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q  <= DivFree;
      cnt_q    <= 6'd0;
      rem_q    <= {DATA_W{1'b0}};
      quo_q    <= {DATA_W{1'b0}};
      dvs_q    <= {DATA_W{1'b0}};
      sgn_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      ready_q  <= DivResultNotReady;
      result_q <= {(2*DATA_W){1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sgn_q    <= sgn_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sgn_d    = sgn_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    ready_d  = ready_q;
    result_d = result_q;
    case (state_q)
      DivFree: begin
        if (div_bus.start_i == DivStart && div_bus.annul_i == DivNotAnnul) begin
          sgn_d  = div_bus.signed_div_i;
          neg1_d = div_bus.opdata1_i[DATA_W-1];
          neg2_d = div_bus.opdata2_i[DATA_W-1];
          // quo_q starts as the dividend magnitude and shifts out as quotient bits shift in.
          quo_d  = (div_bus.signed_div_i && div_bus.opdata1_i[DATA_W-1]) ?
                   twos_neg(div_bus.opdata1_i) : div_bus.opdata1_i;
          dvs_d  = (div_bus.signed_div_i && div_bus.opdata2_i[DATA_W-1]) ?
                   twos_neg(div_bus.opdata2_i) : div_bus.opdata2_i;
          rem_d  = {DATA_W{1'b0}};
          cnt_d  = 6'd0;
          if (div_bus.opdata2_i == {DATA_W{1'b0}}) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
          end
        end else begin
          state_d = DivFree;
        end
      end
      DivByZero: begin
        state_d  = DivEnd;
        ready_d  = DivResultReady;
        result_d = {(2*DATA_W){1'b0}};
      end
      DivOn: begin
        if (div_bus.annul_i == DivAnnul) begin
          state_d  = DivFree;
          cnt_d    = 6'd0;
          ready_d  = DivResultNotReady;
          result_d = {(2*DATA_W){1'b0}};
        end else if (cnt_q != LastCnt) begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = DivEnd;
          cnt_d    = 6'd0;
          ready_d  = DivResultReady;
          result_d = {(sgn_q && neg1_q) ? twos_neg(rem_q) : rem_q,
                      (sgn_q && (neg1_q ^ neg2_q)) ? twos_neg(quo_q) : quo_q};
        end
      end
      DivEnd: begin
        if (div_bus.start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = {(2*DATA_W){1'b0}};
        end else begin
          state_d = DivEnd;
        end
      end
      default: begin
        state_d  = DivFree;
        cnt_d    = 6'd0;
        ready_d  = DivResultNotReady;
        result_d = {(2*DATA_W){1'b0}};
      end
    endcase
  end

  assign div_bus.ready_o  = ready_q;
  assign div_bus.result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, annul, operand isolation and mid-operation reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ready"},  {63'd0, bus.ready_o}, 64'd0);
    chk({tag, " result"}, bus.result_o, 64'd0);
    chk({tag, " state"},  {62'd0, dut.state_q}, {62'd0, DivFree});
  endtask

  // Drives a request and lets the sampling edge (edge 1) pass.
  task automatic launch(input logic sd, input logic [31:0] a, input logic [31:0] b);
    bus.signed_div_i = sd;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    tick();
  endtask

  // Edges 2..33 must keep ready low; edge 34 delivers the result.
  task automatic finish_op(input string tag, input logic [63:0] exp, input bit scramble);
    logic early;
    early = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (scramble) begin
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
      end
      tick();
      early = early | bus.ready_o;
    end
    chk({tag, " early_ready"}, {63'd0, early}, 64'd0);
    tick();
    chk({tag, " ready"},  {63'd0, bus.ready_o}, 64'd1);
    chk({tag, " result"}, bus.result_o, exp);
  endtask

  task automatic release_op(input string tag);
    bus.start_i = 1'b0;
    tick();
    chk_idle({tag, " release"});
  endtask

  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    launch(sd, a, b);
    finish_op(tag, exp, 1'b0);
    release_op(tag);
  endtask

  task automatic run_zero(input string tag, input logic sd, input logic [31:0] a);
    launch(sd, a, 32'd0);
    chk({tag, " ready_e1"}, {63'd0, bus.ready_o}, 64'd0);
    tick();
    chk({tag, " ready_e2"}, {63'd0, bus.ready_o}, 64'd1);
    chk({tag, " result"},   bus.result_o, 64'd0);
    release_op(tag);
  endtask

  initial begin
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    // 100/7 unsigned, then hold start (annul in END must be ignored)
    launch(1'b0, 32'd100, 32'd7);
    finish_op("u100_7", 64'h00000002_0000000E, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.annul_i = (i == 1);
      tick();
      chk("u100_7 hold_ready",  {63'd0, bus.ready_o}, 64'd1);
      chk("u100_7 hold_result", bus.result_o, 64'h00000002_0000000E);
    end
    bus.annul_i = 1'b0;
    release_op("u100_7");
    tick();

    run_div("s-7_2",    1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
    tick();
    run_div("s7_-2",    1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    tick();
    run_div("s-100_-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E);
    tick();
    run_div("uF9_2",    1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC);
    tick();

    run_zero("zero_s", 1'b1, 32'h80000000);
    tick();
    run_zero("zero_u", 1'b0, 32'hFFFFFFFF);
    tick();

    // Annul sampled at edge 10, start held with new operands afterwards
    launch(1'b0, 32'd50, 32'd3);
    repeat (8) tick();
    bus.annul_i = 1'b1;
    tick();
    bus.annul_i = 1'b0;
    chk_idle("annul");
    bus.opdata1_i = 32'hFFFFFFFF;
    bus.opdata2_i = 32'h00000001;
    tick();
    finish_op("after_annul", 64'h00000000_FFFFFFFF, 1'b0);
    release_op("after_annul");
    tick();

    // Operands scrambled every cycle after acceptance
    launch(1'b0, 32'd1000, 32'd10);
    finish_op("scramble", 64'h00000000_00000064, 1'b1);
    release_op("scramble");
    tick();

    run_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    tick();

    // Reset sampled at edge 20, start still held afterwards
    launch(1'b0, 32'd123, 32'd4);
    repeat (18) tick();
    rst = 1'b1;
    tick();
    chk_idle("mid_reset");
    rst = 1'b0;
    tick();
    finish_op("post_reset", 64'h00000003_0000001E, 1'b0);
    release_op("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative 32-bit integer divider serving the EX stage for DIV/DIVU.
- EX raises start_i with operands and keeps requesting a pipeline stall until ready_o arrives. That request reaches the pipeline stall controller as stallreq_from_ex, which freezes PC, IF/ID, ID/EX and EX (stall 6'b001111).
- Result is {remainder, quotient} for the HI/LO write.

Parameters:
- DATA_W, 32, operand width. The iteration count equals DATA_W; the result is 2*DATA_W bits wide.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high (`RstEnable` = 1'b1)
- signed_div_i  input  1  1 = signed division (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  DATA_W  dividend
- opdata2_i  input  DATA_W  divisor
- start_i  input  1  request; EX holds it high until it has consumed ready_o
- annul_i  input  1  cancel the in-flight division (branch/exception flush)
- result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}
- ready_o  output  1  result valid

Behaviour:
- Everything is registered; there are no combinational paths from inputs to outputs.
- States: FREE, BYZERO, ON, END, plus a 6-bit counter cnt.
- Reset (rst=1 at any edge, including mid-operation):
  - state FREE, cnt 0
  - ready_o 0, result_o 0
  - internal datapath cleared
- FREE, start_i=1 and annul_i=0 at an edge:
  - Divisor==0: go to BYZERO.
  - Otherwise: go to ON with cnt=0.
  - Operands are captured at this edge. When signed_div_i=1, negative operands are converted to two's-complement magnitude.
  - The operand signs and signed_div_i are registered at this edge.
  - Later changes on the operand inputs are ignored.
- FREE, start_i=1 and annul_i=1: no action, stay FREE.
- BYZERO: next edge goes to END with the result register = 0.
- ON, annul_i=0, cnt<32: one restoring step per edge, then cnt++.
  - Compare the shifted partial remainder against the divisor magnitude.
  - Subtract when it is ≥ the divisor, and shift in a quotient bit of 1 or 0 accordingly.
- ON, annul_i=0, cnt==32: apply the sign fix and go to END.
  - Sign fix applies only when signed_div_i=1.
  - Quotient is negated when the operand signs differ.
  - Remainder is negated when the dividend was negative.
- ON, annul_i=1 at any edge: go to FREE with ready_o 0 and result_o 0. No result is produced.
- END: ready_o=1 and result_o valid; both hold stable while start_i=1.
  - annul_i is ignored in END.
  - First edge with start_i=0: go to FREE, ready_o 0, result_o 0.
- Latency, counting the edge that samples start as edge 1:
  - Normal division: ready_o is high after edge 34.
  - Divide-by-zero: ready_o is high after edge 2.
- Back-to-back operations: the earliest new start is sampled at the edge after END→FREE. There is a minimum 1 idle cycle between operations.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. This is natural wrap with no flag.
- Width rules:
  - The partial remainder datapath is DATA_W+1 bits so the subtract borrow is visible.
  - All negation is two's complement modulo 2^DATA_W.

Decomposition:
- Shared defines, next to the existing RstEnable/Stop constants:
  - DivFree/DivByZero/DivOn/DivEnd 2-bit encodings
  - DivResultReady/DivResultNotReady
  - DivStart/DivStop
  - DivAnnul/DivNotAnnul
- Optional sub-module div_step: combinational single-iteration compare/subtract/shift, instantiated once.
- FSM, counter and sign handling stay in div_unit.

Test Plan:
- Unsigned 100/7, start held → ready_o rises after edge 34; result_o = {0x00000002, 0x0000000E}. Holding start 3 extra cycles keeps the values; dropping start → ready_o 0 and result_o 0 at the next edge.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/−2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 (any dividend, either signedness) → ready_o after edge 2; result_o = 0.
- Annul asserted for one cycle at edge 10 of ON → ready_o never rises, state FREE. A new start (0xFFFFFFFF/1 unsigned) at the following edge → quotient 0xFFFFFFFF, remainder 0.
- Change opdata1_i/opdata2_i every cycle after acceptance of 1000/10 → result still q 100, r 0. The 0x80000000 / 0xFFFFFFFF signed case → q 0x80000000, r 0.
- rst pulsed at edge 20 of ON → at the next edge ready_o 0, result_o 0, state FREE. A start still held after reset is accepted as a fresh operation.
